// File: rtl/calc_sequencer.sv
// calc_sequencer: operand/opcode sequencer for the 8-bit signed calculator.
// Captures A, B and the opcode on successive enter presses. ADD/SUB/NEG run
// in one cycle, while MUL runs as a WIDTH-cycle shift-add on magnitudes.
// A shown result can be chained in as the next operand A.
module calc_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic [WIDTH-1:0] SW,
    input  logic [1:0]       op_sel,
    input  logic             enter,
    input  logic             clear,
    output logic [WIDTH-1:0] disp_value,
    output logic [2:0]       phase,
    output logic             busy,
    output logic             done,
    output logic             ovf
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [2:0] {
        S_A    = 3'd0,
        S_B    = 3'd1,
        S_OP   = 3'd2,
        S_EXEC = 3'd3,
        S_SHOW = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_NEG = 2'b11
    } op_t;

    state_t             state, state_next;
    op_t                op_reg;
    logic               enter_q, ent;
    logic [WIDTH-1:0]   a_reg, b_reg, result;
    logic               ovf_reg, done_q;
    logic [CW-1:0]      mul_cnt;
    logic [2*WIDTH-1:0] mul_acc, mul_mcand, mul_step, mul_prod;
    logic [WIDTH-1:0]   mul_mplier, a_mag, b_mag;
    logic               mul_neg, mul_last, mul_ovf, exec_done;
    logic [WIDTH-1:0]   alu_val;
    logic               alu_ovf;

    assign ent       = enter & ~enter_q;
    assign mul_last  = (mul_cnt == CW'(WIDTH - 1));
    assign exec_done = (op_reg != OP_MUL) || mul_last;

    // Operand magnitudes, the next shift-add partial sum and the result/overflow of the current op
    always_comb begin
        a_mag    = a_reg[WIDTH-1] ? -a_reg : a_reg;
        b_mag    = b_reg[WIDTH-1] ? -b_reg : b_reg;
        mul_step = mul_acc + (mul_mplier[0] ? mul_mcand : '0);
        mul_prod = mul_neg ? -mul_step : mul_step;
        // In range only when the bits from the sign of the low byte upward all agree
        mul_ovf  = !((&mul_prod[2*WIDTH-1:WIDTH-1]) || !(|mul_prod[2*WIDTH-1:WIDTH-1]));
        alu_val  = '0;
        alu_ovf  = 1'b0;
        case (op_reg)
            OP_ADD: begin
                alu_val = a_reg + b_reg;
                alu_ovf = (a_reg[WIDTH-1] == b_reg[WIDTH-1]) && (alu_val[WIDTH-1] != a_reg[WIDTH-1]);
            end
            OP_SUB: begin
                alu_val = a_reg - b_reg;
                alu_ovf = (a_reg[WIDTH-1] != b_reg[WIDTH-1]) && (alu_val[WIDTH-1] != a_reg[WIDTH-1]);
            end
            OP_NEG: begin
                alu_val = -a_reg;
                alu_ovf = (a_reg == {1'b1, {(WIDTH-1){1'b0}}});
            end
            default: begin
                alu_val = mul_prod[WIDTH-1:0];
                alu_ovf = mul_ovf;
            end
        endcase
    end

    // State register
    always_ff @(posedge CLOCK_50) begin
        if (reset) state <= S_A;
        else       state <= state_next;
    end

    // Next-state logic; clear overrides any enter edge
    always_comb begin
        state_next = state;
        if (clear) begin
            state_next = S_A;
        end else begin
            case (state)
                S_A:     if (ent) state_next = S_B;
                S_B:     if (ent) state_next = S_OP;
                S_OP:    if (ent) state_next = S_EXEC;
                S_EXEC:  if (exec_done) state_next = S_SHOW;
                S_SHOW:  if (ent) state_next = S_B;
                default: state_next = S_A;
            endcase
        end
    end

    // Operand capture, multiplier iteration, result/overflow commit and done pulse
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            enter_q    <= 1'b0;
            done_q     <= 1'b0;
            a_reg      <= '0;
            b_reg      <= '0;
            op_reg     <= OP_ADD;
            result     <= '0;
            ovf_reg    <= 1'b0;
            mul_cnt    <= '0;
            mul_acc    <= '0;
            mul_mcand  <= '0;
            mul_mplier <= '0;
            mul_neg    <= 1'b0;
        end else begin
            enter_q <= enter;
            done_q  <= (state == S_EXEC) && (state_next == S_SHOW);
            if (clear) begin
                a_reg   <= '0;
                b_reg   <= '0;
                result  <= '0;
                ovf_reg <= 1'b0;
                mul_cnt <= '0;
            end else begin
                case (state)
                    S_A: if (ent) a_reg <= SW;
                    S_B: if (ent) b_reg <= SW;
                    S_OP: if (ent) begin
                        op_reg     <= op_t'(op_sel);
                        mul_cnt    <= '0;
                        mul_acc    <= '0;
                        mul_mcand  <= {{WIDTH{1'b0}}, a_mag};
                        mul_mplier <= b_mag;
                        mul_neg    <= a_reg[WIDTH-1] ^ b_reg[WIDTH-1];
                    end
                    S_EXEC: begin
                        // The last step feeds mul_step straight into the product, so acc is not updated then
                        if (op_reg == OP_MUL && !mul_last) begin
                            mul_acc    <= mul_step;
                            mul_mcand  <= mul_mcand << 1;
                            mul_mplier <= mul_mplier >> 1;
                            mul_cnt    <= mul_cnt + CW'(1);
                        end
                        if (exec_done) begin
                            result  <= alu_val;
                            ovf_reg <= alu_ovf;
                        end
                    end
                    S_SHOW: if (ent) a_reg <= result;
                    default: ;
                endcase
            end
        end
    end

    // Output decode
    always_comb begin
        phase = state;
        busy  = (state == S_EXEC);
        done  = done_q;
        ovf   = ovf_reg;
        case (state)
            S_OP:            disp_value = b_reg;
            S_EXEC, S_SHOW:  disp_value = result;
            default:         disp_value = SW;
        endcase
    end

endmodule

// File: tb/tb_calc_sequencer.sv
// tb_calc_sequencer: directed stimulus with a result scoreboard checked on done.
module tb_calc_sequencer;

    logic       CLOCK_50 = 1'b0;
    logic       reset    = 1'b1;
    logic [7:0] SW       = '0;
    logic [1:0] op_sel   = '0;
    logic       enter    = 1'b0;
    logic       clear    = 1'b0;
    logic [7:0] disp_value;
    logic [2:0] phase;
    logic       busy, done, ovf;

    always #5 CLOCK_50 = ~CLOCK_50;

    calc_sequencer #(.WIDTH(8)) dut (
        .CLOCK_50   (CLOCK_50),
        .reset      (reset),
        .SW         (SW),
        .op_sel     (op_sel),
        .enter      (enter),
        .clear      (clear),
        .disp_value (disp_value),
        .phase      (phase),
        .busy       (busy),
        .done       (done),
        .ovf        (ovf)
    );

    typedef struct {
        logic [7:0] val;
        logic       ovf;
        int         busy;
    } exp_t;

    typedef struct {
        string name;
        int    got;
        int    exp;
    } chk_t;

    exp_t sb[$];
    chk_t chkq[$];
    int   n_tests     = 0;
    int   n_fail      = 0;
    int   busy_run    = 0;
    bit   stim_done   = 1'b0;
    bit   fin_checked = 1'b0;
    exp_t e;
    chk_t c;

    // Monitor: drain point checks, score each done pulse, count busy cycles per operation
    always @(negedge CLOCK_50) begin
        if (!reset) begin
            while (chkq.size() > 0) begin
                c = chkq.pop_front();
                n_tests++;
                if (c.got != c.exp) begin
                    n_fail++;
                    $display("FAIL %s: got %0d expected %0d", c.name, c.got, c.exp);
                end
            end
            if (busy) busy_run++;
            if (done) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done=1 expected no pending result");
                end else begin
                    e = sb.pop_front();
                    n_tests += 3;
                    if (disp_value !== e.val) begin
                        n_fail++;
                        $display("FAIL result: got 0x%02h expected 0x%02h", disp_value, e.val);
                    end
                    if (ovf !== e.ovf) begin
                        n_fail++;
                        $display("FAIL ovf: got %0b expected %0b (result 0x%02h)", ovf, e.ovf, e.val);
                    end
                    if (busy_run != e.busy) begin
                        n_fail++;
                        $display("FAIL busy_cycles: got %0d expected %0d (result 0x%02h)", busy_run, e.busy, e.val);
                    end
                end
                busy_run = 0;
            end else if (!busy) begin
                busy_run = 0;
            end
            if (stim_done && !fin_checked) begin
                n_tests++;
                if (sb.size() != 0) begin
                    n_fail++;
                    $display("FAIL pending_results: got %0d expected 0", sb.size());
                end
                fin_checked = 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic check(input string name, input int got, input int exp);
        chkq.push_back('{name, got, exp});
    endtask

    task automatic press();
        enter = 1'b1;
        tick();
        enter = 1'b0;
        tick();
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic wait_show();
        for (int i = 0; i < 60; i++) begin
            if (phase == 3'd4) return;
            tick();
        end
        check("show_timeout", 0, 1);
    endtask

    task automatic issue_op(input logic [1:0] op, input logic [7:0] ev, input logic eo, input int eb);
        op_sel = op;
        sb.push_back('{ev, eo, eb});
        press();
        wait_show();
    endtask

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op,
                          input logic [7:0] ev, input logic eo, input int eb);
        SW = a;
        press();
        SW = b;
        press();
        issue_op(op, ev, eo, eb);
    endtask

    initial begin
        SW = 8'h5A;
        repeat (3) tick();
        reset = 1'b0;
        check("rst_phase", int'(phase), 0);
        check("rst_busy",  int'(busy),  0);
        check("rst_done",  int'(done),  0);
        check("rst_ovf",   int'(ovf),   0);
        check("rst_disp",  int'(disp_value), 8'h5A);

        // 25 + -7 = 18, with the S_OP display showing B
        SW = 8'd25;
        press();
        SW = 8'hF9;
        press();
        check("disp_in_op", int'(disp_value), 8'hF9);
        issue_op(2'b00, 8'h12, 1'b0, 1);

        // chain: 18 - 3 = 15
        press();
        check("chain_phase", int'(phase), 1);
        SW = 8'd3;
        press();
        issue_op(2'b01, 8'h0F, 1'b0, 1);

        do_clear();
        run_op(8'd100, 8'd50, 2'b00, 8'h96, 1'b1, 1);
        do_clear();
        check("clear_phase", int'(phase), 0);
        check("clear_ovf",   int'(ovf),   0);

        run_op(8'h80, 8'd77, 2'b11, 8'h80, 1'b1, 1);
        do_clear();
        run_op(8'hFB, 8'd0,  2'b11, 8'h05, 1'b0, 1);
        do_clear();
        run_op(8'h80, 8'd1,  2'b01, 8'h7F, 1'b1, 1);
        do_clear();
        run_op(8'hF4, 8'd10, 2'b10, 8'h88, 1'b0, 8);
        do_clear();
        run_op(8'd16, 8'd8,  2'b10, 8'h80, 1'b1, 8);
        do_clear();
        run_op(8'h80, 8'd1,  2'b10, 8'h80, 1'b0, 8);
        do_clear();
        run_op(8'h80, 8'hFF, 2'b10, 8'h80, 1'b1, 8);
        do_clear();

        // clear in the middle of a multiply aborts it with no done
        SW = 8'd3;
        press();
        press();
        op_sel = 2'b10;
        press();
        tick();
        tick();
        do_clear();
        check("abort_phase", int'(phase), 0);
        check("abort_busy",  int'(busy),  0);
        run_op(8'd2, 8'd3, 2'b10, 8'h06, 1'b0, 8);
        do_clear();

        // a held key advances exactly once
        SW = 8'd1;
        enter = 1'b1;
        repeat (100) tick();
        enter = 1'b0;
        tick();
        check("held_enter_phase", int'(phase), 1);

        // enter and clear together: clear wins and the edge is consumed
        enter = 1'b1;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clear_vs_enter", int'(phase), 0);
        tick();
        check("edge_consumed", int'(phase), 0);
        enter = 1'b0;
        tick();

        stim_done = 1'b1;
        for (int i = 0; i < 10 && !fin_checked; i++) tick();
        if (!fin_checked) begin
            $display("FAIL monitor_finish: got no final check expected completion");
            $fatal(1);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
